// File: rtl/dom_mul_scheduler_pkg.sv
// Shared constants and helpers for the DOM multiplier scheduler and its masked GF(2^2) multiplier.
package dom_mul_scheduler_pkg;

  localparam int FIFO_DEPTH   = 2;
  localparam int CREDIT_LIMIT = 2;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // GF(2^2) product, polynomial basis, modulus x^2 + x + 1.
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    gf4_mul = {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]),
               (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction

endpackage

// File: rtl/shared_mul_gf2.sv
// Domain-oriented masked GF(2^2) multiplier: one register stage on every inner and cross-domain term.
module shared_mul_gf2
  import dom_mul_scheduler_pkg::*;
#(
  parameter int SHARES    = 2,
  parameter int PIPELINED = 1
) (
  input  logic                          ClkxCI,
  input  logic                          RstxRI,
  input  logic [2*SHARES-1:0]           XxDI,
  input  logic [2*SHARES-1:0]           YxDI,
  input  logic [SHARES*(SHARES-1)-1:0]  ZxDI,
  output logic [2*SHARES-1:0]           QxDO
);

  logic [SHARES-1:0][SHARES-1:0][1:0] term_d, term_q;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_inner
        assign term_d[i][j] = gf4_mul(XxDI[2*i +: 2], YxDI[2*j +: 2]);
      end else begin : g_cross
        // Domains i and j share one 2-bit Z so that it cancels in the recombined product.
        localparam int LO   = (i < j) ? i : j;
        localparam int HI   = (i < j) ? j : i;
        localparam int PAIR = LO * (2*SHARES - LO - 1) / 2 + (HI - LO - 1);
        assign term_d[i][j] = gf4_mul(XxDI[2*i +: 2], YxDI[2*j +: 2]) ^ ZxDI[2*PAIR +: 2];
      end
    end
  end

  if (PIPELINED != 0) begin : g_reg
    always_ff @(posedge ClkxCI or posedge RstxRI) begin
      if (RstxRI) term_q <= '0;
      else        term_q <= term_d;
    end
  end else begin : g_comb
    assign term_q = term_d;
  end

  always_comb begin
    QxDO = '0;
    for (int i = 0; i < SHARES; i++)
      for (int j = 0; j < SHARES; j++)
        QxDO[2*i +: 2] = QxDO[2*i +: 2] ^ term_q[i][j];
  end

endmodule

// File: rtl/dom_mul_scheduler.sv
// Round-robin scheduler sharing one pipelined masked GF(2^2) multiplier among NREQ requesters.
module dom_mul_scheduler
  import dom_mul_scheduler_pkg::*;
#(
  parameter  int SHARES = 2,
  parameter  int NREQ   = 4,
  localparam int IDXW   = idx_width(NREQ),
  localparam int OPW    = 2*SHARES,
  localparam int ZW     = SHARES*(SHARES-1)
) (
  input  logic                 ClkxCI,
  input  logic                 RstxRI,
  input  logic [NREQ-1:0]      ReqxSI,
  input  logic [NREQ*OPW-1:0]  XxDI,
  input  logic [NREQ*OPW-1:0]  YxDI,
  output logic [NREQ-1:0]      GntxSO,
  input  logic [ZW-1:0]        RndxDI,
  input  logic                 RndValidxSI,
  output logic                 RndReadyxSO,
  output logic [OPW-1:0]       QxDO,
  output logic [IDXW-1:0]      QIdxDO,
  output logic                 QValidxSO,
  input  logic                 QReadyxSI
);

  localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CRW = $clog2(CREDIT_LIMIT + 1);

  typedef struct packed {
    logic [IDXW-1:0] idx;
    logic [OPW-1:0]  q;
  } entry_t;

  logic [IDXW-1:0] ptr, win, tag_idx;
  logic            found, issue, xfer, credit_ok, tag_vld;
  logic [CRW-1:0]  credits;
  logic [OPW-1:0]  mul_x, mul_y, mul_q;
  logic [ZW-1:0]   mul_z;
  entry_t          fifo_mem [FIFO_DEPTH];
  logic [FPW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // Round-robin search starting at ptr, wrapping at NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      int cand;
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!found && ReqxSI[cand]) begin
        found = 1'b1;
        win   = IDXW'(cand);
      end
    end
  end

  assign xfer = QValidxSO & QReadyxSI;
  // A credit returned by this cycle's output transfer is reusable at once, so a full
  // pipeline keeps issuing every cycle while the consumer is ready.
  assign credit_ok = (credits < CRW'(CREDIT_LIMIT)) | xfer;
  assign issue     = found & RndValidxSI & credit_ok & ~RstxRI;

  always_comb begin
    GntxSO = '0;
    for (int k = 0; k < NREQ; k++)
      GntxSO[k] = issue && (win == IDXW'(k));
  end

  assign RndReadyxSO = issue;
  assign mul_x = issue ? XxDI[win*OPW +: OPW] : '0;
  assign mul_y = issue ? YxDI[win*OPW +: OPW] : '0;
  assign mul_z = issue ? RndxDI : '0;

  shared_mul_gf2 #(
    .SHARES    (SHARES),
    .PIPELINED (1)
  ) u_mul (
    .ClkxCI (ClkxCI),
    .RstxRI (RstxRI),
    .XxDI   (mul_x),
    .YxDI   (mul_y),
    .ZxDI   (mul_z),
    .QxDO   (mul_q)
  );

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      ptr     <= '0;
      tag_vld <= 1'b0;
      tag_idx <= '0;
      credits <= '0;
    end else begin
      if (issue) ptr <= (win == IDXW'(NREQ-1)) ? '0 : win + 1'b1;
      tag_vld <= issue;
      tag_idx <= issue ? win : '0;
      unique case ({issue, xfer})
        2'b10:   credits <= credits + 1'b1;
        2'b01:   credits <= credits - 1'b1;
        default: credits <= credits;
      endcase
    end
  end

  // Output FIFO; the credit limit guarantees a free slot whenever the tag stage is valid.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int e = 0; e < FIFO_DEPTH; e++) fifo_mem[e] <= '0;
    end else begin
      if (tag_vld) begin
        fifo_mem[wr_ptr] <= '{idx: tag_idx, q: mul_q};
        wr_ptr <= (wr_ptr == FPW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (xfer) rd_ptr <= (rd_ptr == FPW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      unique case ({tag_vld, xfer})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign QValidxSO = (count != '0);
  assign QxDO      = fifo_mem[rd_ptr].q;
  assign QIdxDO    = fifo_mem[rd_ptr].idx;

endmodule

// File: tb/tb_dom_mul_scheduler.sv
// Scoreboard bench: stimulus pushes expected results on each grant, a monitor pops them on transfer.
module tb_dom_mul_scheduler;
  localparam int SHARES = 2;
  localparam int NREQ   = 4;
  localparam int OPW    = 2*SHARES;
  localparam int ZW     = SHARES*(SHARES-1);
  localparam int IDXW   = 2;

  logic                ClkxCI, RstxRI;
  logic [NREQ-1:0]     ReqxSI, GntxSO;
  logic [NREQ*OPW-1:0] XxDI, YxDI;
  logic [ZW-1:0]       RndxDI;
  logic                RndValidxSI, RndReadyxSO;
  logic [OPW-1:0]      QxDO;
  logic [IDXW-1:0]     QIdxDO;
  logic                QValidxSO, QReadyxSI;

  dom_mul_scheduler #(.SHARES(SHARES), .NREQ(NREQ)) dut (
    .ClkxCI(ClkxCI), .RstxRI(RstxRI), .ReqxSI(ReqxSI), .XxDI(XxDI), .YxDI(YxDI),
    .GntxSO(GntxSO), .RndxDI(RndxDI), .RndValidxSI(RndValidxSI), .RndReadyxSO(RndReadyxSO),
    .QxDO(QxDO), .QIdxDO(QIdxDO), .QValidxSO(QValidxSO), .QReadyxSI(QReadyxSI)
  );

  initial ClkxCI = 1'b0;
  always #5 ClkxCI = ~ClkxCI;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic [1:0]      val;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   outst = 0;
  bit   rand_phase = 0;

  // Shift-and-add multiply with reduction by x^2 + x + 1.
  function automatic logic [1:0] ref_mul(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] acc;
    acc = '0;
    for (int i = 0; i < 2; i++)
      if (b[i]) acc = acc ^ ({1'b0, a} << i);
    if (acc[2]) acc = acc ^ 3'b111;
    return acc[1:0];
  endfunction

  function automatic logic [1:0] unmask(input logic [OPW-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int s = 0; s < SHARES; s++) r = r ^ v[2*s +: 2];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer is matched against the oldest expectation.
  always @(negedge ClkxCI) begin
    if (!RstxRI) begin
      if (QValidxSO && QReadyxSI) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_result: got id %0d q %0h, expected none at %0t", QIdxDO, QxDO, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("q_idx", 32'(QIdxDO), 32'(e.idx));
          check("q_data", 32'(unmask(QxDO)), 32'(e.val));
        end
      end
      if (rand_phase) begin
        if (|GntxSO) outst++;
        if (QValidxSO && QReadyxSI) outst--;
        check("outstanding_le_2", 32'(outst <= 2), 32'd1);
      end
    end
  end

  // Checks the grant of the current cycle, records the expected result, advances one cycle.
  task automatic tick(input string name, input logic [NREQ-1:0] exp_gnt);
    @(negedge ClkxCI);
    check(name, 32'(GntxSO), 32'(exp_gnt));
    check({name, "_rndrdy"}, 32'(RndReadyxSO), 32'(|exp_gnt));
    if (exp_gnt == '0) begin
      check({name, "_mulx0"}, 32'(dut.mul_x), 32'd0);
      check({name, "_muly0"}, 32'(dut.mul_y), 32'd0);
      check({name, "_mulz0"}, 32'(dut.mul_z), 32'd0);
    end else begin
      exp_t e;
      int g;
      g = 0;
      for (int k = 0; k < NREQ; k++) if (exp_gnt[k]) g = k;
      e.idx = IDXW'(g);
      e.val = ref_mul(unmask(XxDI[g*OPW +: OPW]), unmask(YxDI[g*OPW +: OPW]));
      sb.push_back(e);
    end
    @(posedge ClkxCI); #1;
  endtask

  task automatic apply_reset();
    RstxRI = 1'b1;
    sb.delete();
    outst = 0;
    ReqxSI = '1;
    RndValidxSI = 1'b1;
    @(negedge ClkxCI);
    check("rst_gnt", 32'(GntxSO), 32'd0);
    check("rst_rndrdy", 32'(RndReadyxSO), 32'd0);
    check("rst_qvalid", 32'(QValidxSO), 32'd0);
    check("rst_q", 32'(QxDO), 32'd0);
    check("rst_qid", 32'(QIdxDO), 32'd0);
    @(posedge ClkxCI); #1;
    RstxRI = 1'b0;
    ReqxSI = '0;
    RndValidxSI = 1'b0;
    QReadyxSI = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge ClkxCI); #1;
    end
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [OPW-1:0]  hold_q;
  logic [IDXW-1:0] hold_id;

  initial begin
    RstxRI = 1'b1; ReqxSI = '0; XxDI = '0; YxDI = '0; RndxDI = '0;
    RndValidxSI = 1'b0; QReadyxSI = 1'b1;
    @(posedge ClkxCI); #1;

    // Single request: X shares {01,11} -> 10, Y shares {10,10} -> 00, product 00.
    apply_reset();
    XxDI = 16'h5A0D; YxDI = 16'h3C0A; RndxDI = 2'b10;
    ReqxSI = 4'b0001; RndValidxSI = 1'b1;
    tick("t1_gnt", 4'b0001);
    ReqxSI = '0; RndValidxSI = 1'b0;
    @(negedge ClkxCI);
    check("t1_qvalid_t1", 32'(QValidxSO), 32'd0);
    @(posedge ClkxCI); #1;
    @(negedge ClkxCI);
    check("t1_qvalid_t2", 32'(QValidxSO), 32'd1);
    check("t1_qid", 32'(QIdxDO), 32'd0);
    check("t1_q_unmasked", 32'(unmask(QxDO)), 32'd0);
    @(posedge ClkxCI); #1;
    drain();

    // Round-robin with all requesters active and the consumer always ready.
    apply_reset();
    XxDI = 16'hB7E2; YxDI = 16'h6D19; RndxDI = 2'b01;
    ReqxSI = 4'b1111; RndValidxSI = 1'b1;
    tick("t2_g0", 4'b0001);
    tick("t2_g1", 4'b0010);
    tick("t2_g2", 4'b0100);
    tick("t2_g3", 4'b1000);
    tick("t2_g4", 4'b0001);
    ReqxSI = '0; RndValidxSI = 1'b0;
    drain();

    // Randomness starvation: no issue until Z is valid, then same-cycle grant.
    apply_reset();
    XxDI = 16'h1F2E; YxDI = 16'hC3A5; RndxDI = 2'b11;
    ReqxSI = 4'b0101;
    tick("t3_starve0", 4'b0000);
    tick("t3_starve1", 4'b0000);
    tick("t3_starve2", 4'b0000);
    RndValidxSI = 1'b1;
    tick("t3_rnd_up", 4'b0001);
    ReqxSI = 4'b0100;
    tick("t3_next", 4'b0100);
    ReqxSI = '0; RndValidxSI = 1'b0;
    drain();

    // Backpressure: two issues fill the credits, head stays stable, then drain in order.
    apply_reset();
    XxDI = 16'h9C63; YxDI = 16'h4EB7; RndxDI = 2'b10;
    QReadyxSI = 1'b0; ReqxSI = 4'b1111; RndValidxSI = 1'b1;
    tick("t4_g0", 4'b0001);
    tick("t4_g1", 4'b0010);
    tick("t4_full", 4'b0000);
    @(negedge ClkxCI);
    hold_q = QxDO; hold_id = QIdxDO;
    check("t4_qvalid", 32'(QValidxSO), 32'd1);
    check("t4_head_id", 32'(QIdxDO), 32'd0);
    check("t4_head_q", 32'(unmask(QxDO)), 32'(ref_mul(unmask(XxDI[3:0]), unmask(YxDI[3:0]))));
    check("t4_gnt_blocked", 32'(GntxSO), 32'd0);
    @(posedge ClkxCI); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge ClkxCI);
      check("t4_q_stable", 32'(QxDO), 32'(hold_q));
      check("t4_id_stable", 32'(QIdxDO), 32'(hold_id));
      check("t4_gnt_held", 32'(GntxSO), 32'd0);
      @(posedge ClkxCI); #1;
    end
    QReadyxSI = 1'b1;
    tick("t4_resume_g2", 4'b0100);
    tick("t4_resume_g3", 4'b1000);
    tick("t4_resume_g0", 4'b0001);
    ReqxSI = '0; RndValidxSI = 1'b0;
    drain();

    // Reset one cycle after an issue discards it and returns the pointer to requester 0.
    apply_reset();
    XxDI = 16'h7777; YxDI = 16'hEEEE; RndxDI = 2'b01;
    ReqxSI = 4'b0001; RndValidxSI = 1'b1;
    tick("t5_g0", 4'b0001);
    ReqxSI = '0; RndValidxSI = 1'b0;
    RstxRI = 1'b1;
    sb.delete();
    repeat (2) @(posedge ClkxCI);
    #1 RstxRI = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ClkxCI);
      check("t5_no_result", 32'(QValidxSO), 32'd0);
      @(posedge ClkxCI); #1;
    end
    ReqxSI = 4'b0011; RndValidxSI = 1'b1;
    tick("t5_ptr_reset", 4'b0001);
    ReqxSI = '0; RndValidxSI = 1'b0;
    drain();

    // Random regression against the reference multiply and a round-robin model.
    apply_reset();
    rand_phase = 1'b1;
    begin
      int mptr;
      mptr = 0;
      for (int n = 0; n < 10000; n++) begin
        logic [NREQ-1:0] eg;
        ReqxSI      = 4'($urandom);
        RndValidxSI = ($urandom_range(0, 3) != 0);
        XxDI        = 16'($urandom);
        YxDI        = 16'($urandom);
        RndxDI      = 2'($urandom);
        eg = '0;
        if (RndValidxSI && (ReqxSI != '0)) begin
          int g;
          g = -1;
          for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (mptr + k) % NREQ;
            if (g < 0 && ReqxSI[c]) g = c;
          end
          eg[g] = 1'b1;
          mptr = (g + 1) % NREQ;
        end
        tick("rnd_gnt", eg);
      end
    end
    ReqxSI = '0; RndValidxSI = 1'b0;
    drain();
    rand_phase = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
